nes_controller_model: RTL and testbench

- Behavioural model of one standard NES joypad: an 8-bit parallel-in/serial-out latch, equivalent to a CD4021.
- Sits on the CPU clock next to the CPU-bus controller port ($4016/$4017 logic).
- The port drives `strobe` (latch) and `rd` (read pulse). The model returns one button bit per read on `data`.
- Used in simulation benches to inject button presses into the system.

---
 rtl/nes_ctrl_pkg.sv | 18 +
 rtl/nes_controller_model.sv | 76 +++++++
 tb/tb_nes_controller_model.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/nes_ctrl_pkg.sv
// nes_ctrl_pkg
// Shared constants for the NES joypad model and the benches that drive it.
// Button indices give the bit position of each button inside the parallel
// btns vector. Bit 0 is the first bit read after a latch.
package nes_ctrl_pkg;

  localparam int NBTN_DEFAULT = 8;

  localparam int BTN_A      = 0;
  localparam int BTN_B      = 1;
  localparam int BTN_SELECT = 2;
  localparam int BTN_START  = 3;
  localparam int BTN_UP     = 4;
  localparam int BTN_DOWN   = 5;
  localparam int BTN_LEFT   = 6;
  localparam int BTN_RIGHT  = 7;

endpackage : nes_ctrl_pkg

// File: rtl/nes_controller_model.sv
// nes_controller_model
// Behavioural model of one standard NES joypad. It is an 8-bit
// parallel-in/serial-out latch that behaves like a CD4021. It runs on the
// CPU clock beside the $4016/$4017 port logic.
//
// Ports:
//   clk    - CPU clock. All state changes happen on its rising edge.
//   rst    - asynchronous reset, active high.
//   strobe - latch control. While it is high, every clock edge reloads the
//            register from btns, and data shows btns[0] directly.
//   rd     - read request. Only the rising edge of rd counts, so holding rd
//            high shifts once.
//   btns   - live button state, 1 = pressed (A, B, Select, Start, Up, Down,
//            Left, Right from bit 0).
//   data   - current serial bit, 1 = pressed.
module nes_controller_model
  import nes_ctrl_pkg::*;
#(
  parameter int   NBTN = NBTN_DEFAULT,
  parameter logic FILL = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            strobe,
  input  logic            rd,
  input  logic [NBTN-1:0] btns,
  output logic            data
);

  logic [NBTN-1:0] shreg_reg;
  logic [NBTN-1:0] shreg_next;
  logic [NBTN-1:0] shreg_shifted;
  logic            rd_q_reg;
  logic            rd_rise;

  // Shift toward bit 0. FILL enters at the top, so once every button bit
  // has been read, the register keeps returning FILL.
  generate
    for (genvar gi = 0; gi < NBTN; gi++) begin : g_shift
      if (gi == NBTN - 1) begin : g_top
        assign shreg_shifted[gi] = FILL;
      end else begin : g_mid
        assign shreg_shifted[gi] = shreg_reg[gi+1];
      end
    end
  endgenerate

  // rd_q_reg follows rd even while strobe is high. A read that is already
  // held high when strobe drops therefore does not cause a shift.
  assign rd_rise = rd & ~rd_q_reg;

  // A load has priority over a shift that happens in the same cycle.
  always_comb begin
    shreg_next = shreg_reg;
    if (strobe) begin
      shreg_next = btns;
    end else if (rd_rise) begin
      shreg_next = shreg_shifted;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg_reg <= '0;
      rd_q_reg  <= 1'b0;
    end else begin
      shreg_reg <= shreg_next;
      rd_q_reg  <= rd;
    end
  end

  // While strobe is high, the latch passes the A button through directly.
  // This also holds during reset.
  assign data = strobe ? btns[0] : shreg_reg[0];

endmodule : nes_controller_model

// File: tb/tb_nes_controller_model.sv
module tb_nes_controller_model;
  import nes_ctrl_pkg::*;

  logic       clk;
  logic       rst;
  logic       strobe;
  logic       rd;
  logic [7:0] btns;
  logic       data;

  int tests_run;
  int tests_failed;

  nes_controller_model #(.NBTN(8), .FILL(1'b1)) dut (
    .clk   (clk),
    .rst   (rst),
    .strobe(strobe),
    .rd    (rd),
    .btns  (btns),
    .data  (data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change 1 time unit after a rising edge, which keeps them away from the active edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_rd();
    rd = 1'b1;
    tick();
    rd = 1'b0;
    tick();
  endtask

  task automatic load(input logic [7:0] value);
    strobe = 1'b1;
    btns   = value;
    tick();
    strobe = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    logic exp;
    strobe = 1'b0; rd = 1'b0; btns = 8'h00; rst = 1'b1;
    tick(); tick();
    exp = 1'b0;
    tests_run++;
    if (data !== exp) begin
      tests_failed++;
      $display("FAIL reset_data_idle: got %b want %b", data, exp);
    end
    strobe = 1'b1; btns = 8'h01; #1;
    exp = 1'b1;
    tests_run++;
    if (data !== exp) begin
      tests_failed++;
      $display("FAIL reset_strobe_pass: got %b want %b", data, exp);
    end
    strobe = 1'b0; #1;
    exp = 1'b0;
    tests_run++;
    if (data !== exp) begin
      tests_failed++;
      $display("FAIL reset_shreg_zero: got %b want %b", data, exp);
    end
    rst = 1'b0;
    tick();
    $display("[TB] reset: data after release %b", data);
  endtask

  task automatic test_start_sequence();
    logic [7:0] b;
    logic exp;
    b = 8'h00;
    b[BTN_START] = 1'b1;
    load(b);
    for (int i = 0; i < 11; i++) begin
      exp = (i < 8) ? b[i] : 1'b1;
      tests_run++;
      if (data !== exp) begin
        tests_failed++;
        $display("FAIL start_seq read %0d: got %b want %b", i, data, exp);
      end
      $display("[TB] start_seq read %0d data=%b", i, data);
      pulse_rd();
    end
  endtask

  task automatic test_strobe_transparent();
    logic exp;
    logic [7:0] v;
    strobe = 1'b1; btns = 8'h00; #1;
    exp = 1'b0;
    tests_run++;
    if (data !== exp) begin
      tests_failed++;
      $display("FAIL transp_0: got %b want %b", data, exp);
    end
    btns = 8'h01; #1;
    exp = 1'b1;
    tests_run++;
    if (data !== exp) begin
      tests_failed++;
      $display("FAIL transp_1: got %b want %b", data, exp);
    end
    tick();
    btns = 8'h00; #1;
    exp = 1'b0;
    tests_run++;
    if (data !== exp) begin
      tests_failed++;
      $display("FAIL transp_back0: got %b want %b", data, exp);
    end
    // Send read pulses while strobe is high. None of them may shift.
    pulse_rd();
    pulse_rd();
    v = 8'b0000_0101;
    btns = v;
    tick();
    strobe = 1'b0; #1;
    for (int i = 0; i < 3; i++) begin
      exp = v[i];
      tests_run++;
      if (data !== exp) begin
        tests_failed++;
        $display("FAIL transp_after read %0d: got %b want %b", i, data, exp);
      end
      $display("[TB] transp_after read %0d data=%b", i, data);
      pulse_rd();
    end
  endtask

  task automatic test_rd_held();
    logic exp;
    logic [7:0] v;
    v = 8'h81;
    load(v);
    exp = 1'b1;
    tests_run++;
    if (data !== exp) begin
      tests_failed++;
      $display("FAIL held_first: got %b want %b", data, exp);
    end
    rd = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      exp = 1'b0;
      tests_run++;
      if (data !== exp) begin
        tests_failed++;
        $display("FAIL held cycle %0d: got %b want %b", c, data, exp);
      end
    end
    rd = 1'b0;
    tick();
    // Exactly one shift so far, so the following pulses read bits 2..7.
    for (int i = 2; i < 8; i++) begin
      pulse_rd();
      exp = v[i];
      tests_run++;
      if (data !== exp) begin
        tests_failed++;
        $display("FAIL held_after bit %0d: got %b want %b", i, data, exp);
      end
      $display("[TB] held_after bit %0d data=%b", i, data);
    end
  endtask

  task automatic test_load_then_change();
    logic exp;
    logic [7:0] v;
    v = 8'h01;
    load(v);
    btns = 8'hFF;
    for (int i = 0; i < 9; i++) begin
      exp = (i < 8) ? v[i] : 1'b1;
      tests_run++;
      if (data !== exp) begin
        tests_failed++;
        $display("FAIL hold_load read %0d: got %b want %b", i, data, exp);
      end
      $display("[TB] hold_load read %0d data=%b", i, data);
      pulse_rd();
    end
  endtask

  task automatic test_reset_mid();
    logic exp;
    load(8'hFF);
    for (int i = 0; i < 3; i++) begin
      exp = 1'b1;
      tests_run++;
      if (data !== exp) begin
        tests_failed++;
        $display("FAIL rstmid pre %0d: got %b want %b", i, data, exp);
      end
      pulse_rd();
    end
    rst = 1'b1; #1;
    exp = 1'b0;
    tests_run++;
    if (data !== exp) begin
      tests_failed++;
      $display("FAIL rstmid async: got %b want %b", data, exp);
    end
    tick();
    rst = 1'b0;
    tick();
    for (int i = 0; i < 10; i++) begin
      exp = (i < 8) ? 1'b0 : 1'b1;
      tests_run++;
      if (data !== exp) begin
        tests_failed++;
        $display("FAIL rstmid post %0d: got %b want %b", i, data, exp);
      end
      $display("[TB] rstmid post read %0d data=%b", i, data);
      pulse_rd();
    end
  endtask

  task automatic test_back_to_back();
    logic exp;
    // strobe high and rd rising in the same cycle: the load wins.
    strobe = 1'b1; rd = 1'b1; btns = 8'b0000_0010;
    tick();
    strobe = 1'b0; rd = 1'b0; #1;
    exp = 1'b0;
    tests_run++;
    if (data !== exp) begin
      tests_failed++;
      $display("FAIL simul_first: got %b want %b", data, exp);
    end
    tick();
    pulse_rd();
    exp = 1'b1;
    tests_run++;
    if (data !== exp) begin
      tests_failed++;
      $display("FAIL simul_second: got %b want %b", data, exp);
    end
    // rd is already high when strobe falls, so no shift may happen.
    strobe = 1'b1; rd = 1'b1; btns = 8'b0000_0001;
    tick();
    strobe = 1'b0;
    tick(); tick();
    exp = 1'b1;
    tests_run++;
    if (data !== exp) begin
      tests_failed++;
      $display("FAIL rd_high_at_fall: got %b want %b", data, exp);
    end
    rd = 1'b0;
    tick();
    pulse_rd();
    exp = 1'b0;
    tests_run++;
    if (data !== exp) begin
      tests_failed++;
      $display("FAIL rd_high_next: got %b want %b", data, exp);
    end
    $display("[TB] back_to_back done data=%b", data);
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst = 1'b1; strobe = 1'b0; rd = 1'b0; btns = 8'h00;
    test_reset();
    test_start_sequence();
    test_strobe_transparent();
    test_rd_held();
    test_load_then_change();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule : tb_nes_controller_model
